// File: rtl/dds_freq_meter.sv
// dds_freq_meter: frequency meter for a valid-qualified signed wave stream.
// It detects rising zero crossings and counts the valid samples spanned by
// NPER periods. A restoring divider then recovers the accumulator step,
// P_est = (NPER << M) / period, saturated to 2^M-1.
// Optional build macro DDS_METER_HYST_EN: hysteresis crossing detector
// (a crossing needs a sample <= -HYST and then a sample >= +HYST).
module dds_freq_meter #(
  parameter int M    = 16,
  parameter int W    = 12,
  parameter int NPER = 4,
  parameter int CW   = 20,
  parameter int HYST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_en,
  input  logic                ic_val_data,
  input  logic signed [W-1:0] id_wave,
  output logic [M-1:0]        od_p_est,
  output logic [CW-1:0]       od_period,
  output logic                oc_val_data,
  output logic                oc_busy,
  output logic                oc_ovf
);

  localparam int DW = M + $clog2(NPER + 1);
  localparam int SW = $clog2(DW + 1);
  localparam logic [DW-1:0] NPER_V   = DW'(NPER);
  localparam logic [DW-1:0] DIVIDEND = NPER_V << M;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [7:0]    NPER_C   = 8'(NPER);
  localparam logic [SW-1:0] LAST_STEP = SW'(DW - 1);

  if (NPER < 1 || NPER > 255 || HYST < 0) begin : g_param_check
    $error("dds_freq_meter: NPER must be 1..255 and HYST non-negative");
  end

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_COUNT, S_DIV, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt, cnt_inc;
  logic [7:0]    xcnt, xcnt_inc;
  logic [SW-1:0] step;
  logic          samp_live;
  logic          xing;

  logic [CW:0]   rem_sh;
  logic [CW-1:0] rem_p1, rem_nxt;
  logic [DW-1:0] quo_p1, quo_nxt;
  logic [CW-1:0] dvs_p1;

  // Quotient saturation into the M-bit step range
  function automatic logic [M-1:0] sat_step(input logic [DW-1:0] q);
    if (|q[DW-1:M]) return '1;
    return q[M-1:0];
  endfunction

  assign samp_live = ic_en && ic_val_data && (state == S_ARM || state == S_COUNT);
  assign cnt_inc   = cnt + 1'b1;
  assign xcnt_inc  = xcnt + 8'd1;

`ifdef DDS_METER_HYST_EN
  localparam logic signed [W-1:0] HYST_P = W'(HYST);
  localparam logic signed [W-1:0] HYST_N = -HYST_P;
  logic armed;

  assign xing = samp_live && armed && (id_wave >= HYST_P);

  // Armed flag: set by a sample at or below -HYST, consumed by the crossing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (state == S_IDLE) begin
      armed <= 1'b0;
    end else if (samp_live) begin
      if (xing) armed <= 1'b0;
      else if (id_wave <= HYST_N) armed <= 1'b1;
    end
  end
`else
  localparam logic signed [W-1:0] ZERO = '0;
  logic signed [W-1:0] prev;
  logic                prev_valid;

  assign xing = samp_live && prev_valid && (prev < ZERO) && (id_wave >= ZERO);

  // Previous valid sample, only tracked while looking for crossings
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (state == S_IDLE || state == S_DIV || state == S_DONE) begin
      prev_valid <= 1'b0;
    end else if (samp_live) begin
      prev       <= id_wave;
      prev_valid <= 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; dropping ic_en aborts to IDLE from anywhere
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_ARM;
      S_ARM:   if (xing) state_nxt = S_COUNT;
      S_COUNT: begin
        if (samp_live) begin
          if (cnt_inc == CNT_MAX)                state_nxt = S_ARM;
          else if (xing && xcnt_inc == NPER_C)   state_nxt = S_DIV;
        end
      end
      S_DIV:   if (step == LAST_STEP) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_ARM;
      default: state_nxt = S_IDLE;
    endcase
    if (!ic_en) state_nxt = S_IDLE;
  end

  // Output decode
  always_comb begin
    oc_busy = (state == S_DIV);
  end

  // Period/crossing counters, divider step counter and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      xcnt   <= '0;
      step   <= '0;
      oc_ovf <= 1'b0;
    end else begin
      step <= (state == S_DIV && ic_en) ? step + 1'b1 : '0;
      if (!ic_en || state == S_IDLE) begin
        cnt  <= '0;
        xcnt <= '0;
      end else if (state == S_ARM && xing) begin
        cnt    <= '0;
        xcnt   <= '0;
        oc_ovf <= 1'b0;
      end else if (state == S_COUNT && samp_live) begin
        cnt <= cnt_inc;
        if (xing) xcnt <= xcnt_inc;
        if (cnt_inc == CNT_MAX) oc_ovf <= 1'b1;
      end
    end
  end

  // Restoring division step: shift in one dividend bit, subtract if it fits
  always_comb begin
    rem_sh = {rem_p1, quo_p1[DW-1]};
    if (rem_sh >= {1'b0, dvs_p1}) begin
      rem_nxt = CW'(rem_sh - {1'b0, dvs_p1});
      quo_nxt = {quo_p1[DW-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[CW-1:0];
      quo_nxt = {quo_p1[DW-2:0], 1'b0};
    end
  end

  // Stage p1: divider datapath, loaded on the final crossing, stepped in DIV
  always_ff @(posedge clk) begin
    if (state == S_COUNT && state_nxt == S_DIV) begin
      rem_p1 <= '0;
      quo_p1 <= DIVIDEND;
      dvs_p1 <= cnt_inc;
    end else if (state == S_DIV) begin
      rem_p1 <= rem_nxt;
      quo_p1 <= quo_nxt;
    end
  end

  // Stage p2: result registers and one-cycle update pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      od_p_est    <= '0;
      od_period   <= '0;
      oc_val_data <= 1'b0;
    end else begin
      oc_val_data <= (state == S_DONE) && ic_en;
      if (state == S_DONE && ic_en) begin
        od_p_est  <= sat_step(quo_p1);
        od_period <= dvs_p1;
      end
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Bench for dds_freq_meter: sine tones from a local phase accumulator,
// expected results queued before each run and compared on every pulse.
module tb_dds_freq_meter;

  localparam int M    = 16;
  localparam int W    = 12;
  localparam int NPER = 4;
  localparam int CW   = 20;
  localparam int DW   = M + $clog2(NPER + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, en, val;
  logic signed [W-1:0] wave;
  logic [M-1:0]        p_est;
  logic [CW-1:0]       period;
  logic                vd, busy, ovf;

  logic                en8, val8;
  logic signed [W-1:0] wave8;
  logic [M-1:0]        p_est8;
  logic [7:0]          period8;
  logic                vd8, busy8, ovf8;

  dds_freq_meter #(.M(M), .W(W), .NPER(NPER), .CW(CW), .HYST(4)) dut (
    .clk(clk), .rst(rst), .ic_en(en), .ic_val_data(val), .id_wave(wave),
    .od_p_est(p_est), .od_period(period), .oc_val_data(vd),
    .oc_busy(busy), .oc_ovf(ovf)
  );

  dds_freq_meter #(.M(M), .W(W), .NPER(NPER), .CW(8), .HYST(4)) dut8 (
    .clk(clk), .rst(rst), .ic_en(en8), .ic_val_data(val8), .id_wave(wave8),
    .od_p_est(p_est8), .od_period(period8), .oc_val_data(vd8),
    .oc_busy(busy8), .oc_ovf(ovf8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct { int per; int pest; } exp_t;
  exp_t sb[$];

  function automatic int exp_pest(input int per);
    int q;
    q = (NPER << M) / per;
    return (q > 65535) ? 65535 : q;
  endfunction

  function automatic logic signed [W-1:0] sin_sample(input logic [15:0] ph, input int dither);
    real x;
    int  s;
    x = 2000.0 * $sin(6.283185307179586 * real'(ph) / 65536.0);
    s = $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5) + dither;
    return W'(s);
  endfunction

  // Monitor: busy length, pulse shape/latency, scoreboard compare
  int  pulse_cnt = 0, pulse8_cnt = 0, busy_run = 0, since_busy = 100;
  bit  range_mode = 0, abort_flag = 0, prev_vd = 0;
  exp_t e;

  always @(negedge clk) begin
    if (busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      if (!abort_flag) chk("busy_len", busy_run, DW);
      busy_run   = 0;
      since_busy = 0;
    end else begin
      since_busy++;
    end
    if (vd) begin
      pulse_cnt++;
      chk("pulse_latency", since_busy, 1);
      if (prev_vd) chk("pulse_width", 2, 1);
      if (range_mode) begin
        chk("p1000_period_range", (period == 262 || period == 263), 1);
        chk("p1000_pest_range", (p_est == 996 || p_est == 1000), 1);
      end else if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("period", period, e.per);
        chk("p_est", p_est, e.pest);
      end
    end
    prev_vd = vd;
    if (vd8) begin
      pulse8_cnt++;
      chk("ovf_dut_pulse", 1, 0);
    end
  end

  // Drive a tone until `target` pulses arrive or the cycle budget runs out
  task automatic run_tone(input int p, input bit toggle, input bit chatter,
                          input int target, input int budget);
    logic [15:0] ph;
    int base, c;
    ph = '0; base = pulse_cnt; c = 0;
    en = 1'b1;
    while (pulse_cnt < base + target && c < budget) begin
      @(posedge clk); #1;
      if (toggle && (c % 2 == 1)) begin
        val = 1'b0;
        wave = 12'sd0;
      end else begin
        val  = 1'b1;
        wave = sin_sample(ph, chatter ? ((c % 4 < 2) ? 1 : -1) : 0);
        ph   = ph + p[15:0];
      end
      c++;
    end
    chk("tone_pulses_arrived", (pulse_cnt - base) >= target, 1);
    @(posedge clk); #1;
    en = 1'b0; val = 1'b0;
  endtask

  initial begin
    logic [15:0] ph;
    int base;
    rst = 1'b1; en = 1'b0; val = 1'b0; wave = '0;
    en8 = 1'b0; val8 = 1'b0; wave8 = '0;

    // Reset state
    @(negedge clk);
    chk("rst_p_est", p_est, 0);
    chk("rst_period", period, 0);
    chk("rst_val", vd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Period counter overflow on the CW=8 instance
    en8 = 1'b1;
    @(posedge clk); #1;
    val8 = 1'b1; wave8 = -12'sd50;
    @(posedge clk); #1;
    wave8 = 12'sd100;
    @(posedge clk);
    repeat (254) @(posedge clk);
    #1 chk("ovf_before_255", ovf8, 0);
    @(posedge clk); #1;
    chk("ovf_at_255", ovf8, 1);
    chk("ovf_busy", busy8, 0);
    repeat (10) @(posedge clk);
    #1 chk("ovf_sticky", ovf8, 1);
    wave8 = -12'sd50;
    @(posedge clk); #1;
    wave8 = 12'sd100;
    @(posedge clk); #1;
    chk("ovf_cleared_on_rearm", ovf8, 0);
    en8 = 1'b0; val8 = 1'b0;

    // P=4096, continuous valid
    sb.push_back('{64, exp_pest(64)});
    sb.push_back('{64, exp_pest(64)});
    run_tone(4096, 1'b0, 1'b0, 2, 600);
    chk("sb_empty_p4096", sb.size(), 0);

    // P=1000: period/estimate within rounding window
    range_mode = 1'b1;
    run_tone(1000, 1'b0, 1'b0, 3, 2000);
    range_mode = 1'b0;
    chk("p1000_no_ovf", ovf, 0);

    // P=4096 with valid gaps every other cycle
    sb.push_back('{64, exp_pest(64)});
    sb.push_back('{64, exp_pest(64)});
    run_tone(4096, 1'b1, 1'b0, 2, 1200);
    chk("sb_empty_gaps", sb.size(), 0);

    // Abort during DIV: no pulse, outputs hold, then a fresh measurement
    abort_flag = 1'b1;
    ph = '0; en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (busy) break;
      val = 1'b1; wave = sin_sample(ph, 0); ph = ph + 16'd4096;
    end
    chk("abort_busy_seen", busy, 1);
    repeat (5) @(posedge clk);
    #1 en = 1'b0; val = 1'b0;
    base = pulse_cnt;
    @(posedge clk); #1;
    chk("abort_busy_low", busy, 0);
    repeat (30) @(posedge clk);
    #1 chk("abort_no_pulse", pulse_cnt - base, 0);
    chk("abort_hold_p_est", p_est, 4096);
    chk("abort_hold_period", period, 64);
    abort_flag = 1'b0;
    sb.push_back('{64, exp_pest(64)});
    run_tone(4096, 1'b0, 1'b0, 1, 600);
    chk("sb_empty_after_abort", sb.size(), 0);

`ifdef DDS_METER_HYST_EN
    // Chatter of +-1 LSB must not create extra crossings
    sb.push_back('{64, exp_pest(64)});
    sb.push_back('{64, exp_pest(64)});
    run_tone(4096, 1'b0, 1'b1, 2, 600);
    chk("sb_empty_hyst", sb.size(), 0);
`endif

    // Asynchronous reset in the middle of counting
    ph = '0; en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      val = 1'b1; wave = sin_sample(ph, 0); ph = ph + 16'd4096;
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_p_est", p_est, 0);
    chk("async_rst_period", period, 0);
    chk("async_rst_val", vd, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ovf", ovf, 0);
    #1 rst = 1'b0; en = 1'b0; val = 1'b0;
    repeat (3) @(posedge clk);

    chk("ovf_dut_pulses", pulse8_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
